idecode_stage: RTL

//  Parametrised RV32I/RV64I instruction-decode pipeline stage between ifetch and execute.

---
 rtl/idecode_stage.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/idecode_stage.sv
// RV32I/RV64I decode stage: one registered slot, 1-cycle accept-to-valid latency.
// Backpressure: in_ready = !out_valid | out_ready; a stalled slot holds every output stable.
module idecode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            alu_src_pc,
  output logic            word_op,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            jump,
  output logic            jalr,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // instr[30] selects SUB only in register form; in both forms it selects SRA for funct3=101
  function automatic logic [3:0] arith_op(input logic [2:0] f, input logic alt, input logic reg_form);
    logic [3:0] op;
    case (f)
      3'b000:  op = (reg_form && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_shift;
  logic       f7_reg_ok;
  logic       f3_word_ok;

  assign opc        = in_instr[6:0];
  assign f3         = in_instr[14:12];
  assign f7         = in_instr[31:25];
  assign is_shift   = (f3 == 3'b001) || (f3 == 3'b101);
  assign f7_reg_ok  = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));
  assign f3_word_ok = (f3 == 3'b000) || is_shift;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_alu_op;
  logic            d_src_imm, d_src_pc, d_word, d_rw, d_mr, d_mw, d_br, d_jump, d_jalr, d_ill;

  always_comb begin
    d_imm     = '0;
    d_alu_op  = ALU_ADD;
    d_src_imm = 1'b0;
    d_src_pc  = 1'b0;
    d_word    = 1'b0;
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_jump    = 1'b0;
    d_jalr    = 1'b0;
    d_ill     = 1'b0;
    case (opc)
      OPC_LOAD: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1; d_mr = 1'b1;
        d_ill = !((f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                  (RV64 && (f3 inside {3'b011, 3'b110})));
      end
      OPC_STORE: begin
        d_imm = imm_s; d_src_imm = 1'b1; d_mw = 1'b1;
        d_ill = !((f3 inside {3'b000, 3'b001, 3'b010}) || (RV64 && f3 == 3'b011));
      end
      OPC_BRANCH: begin
        d_imm = imm_b; d_alu_op = ALU_SUB; d_br = 1'b1;
        d_ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        d_imm = imm_j; d_src_imm = 1'b1; d_src_pc = 1'b1; d_rw = 1'b1; d_jump = 1'b1;
      end
      OPC_JALR: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1; d_jump = 1'b1; d_jalr = 1'b1;
      end
      OPC_LUI: begin
        d_imm = imm_u; d_alu_op = ALU_PASSB; d_src_imm = 1'b1; d_rw = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u; d_src_imm = 1'b1; d_src_pc = 1'b1; d_rw = 1'b1;
      end
      OPC_OP_IMM: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1;
        d_alu_op = arith_op(f3, in_instr[30], 1'b0);
        d_ill = !RV64 && is_shift && in_instr[25];
      end
      OPC_OP_IMM32: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1; d_word = RV64;
        d_alu_op = arith_op(f3, in_instr[30], 1'b0);
        d_ill = !RV64 || !f3_word_ok || (is_shift && in_instr[25]);
      end
      OPC_OP: begin
        d_rw = 1'b1;
        d_alu_op = arith_op(f3, in_instr[30], 1'b1);
        d_ill = !f7_reg_ok;
      end
      OPC_OP32: begin
        d_rw = 1'b1; d_word = RV64;
        d_alu_op = arith_op(f3, in_instr[30], 1'b1);
        d_ill = !RV64 || !f3_word_ok || !f7_reg_ok;
      end
      // FENCE and SYSTEM retire as an ADDI-shaped no-op with no side effects
      OPC_MISC_MEM, OPC_SYSTEM: begin
        d_imm = imm_i; d_src_imm = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      funct3      <= '0;
      imm         <= '0;
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b1;
      alu_src_pc  <= 1'b0;
      word_op     <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      is_branch   <= 1'b0;
      jump        <= 1'b0;
      jalr        <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      rd          <= in_instr[11:7];
      rs1         <= in_instr[19:15];
      rs2         <= in_instr[24:20];
      funct3      <= f3;
      imm         <= d_imm;
      alu_op      <= d_alu_op;
      alu_src_imm <= d_src_imm;
      alu_src_pc  <= d_src_pc;
      word_op     <= d_word;
      // an illegal slot still travels down the pipe but must not commit anything
      reg_write   <= d_rw && (in_instr[11:7] != 5'd0) && !d_ill;
      mem_read    <= d_mr && !d_ill;
      mem_write   <= d_mw && !d_ill;
      is_branch   <= d_br && !d_ill;
      jump        <= d_jump && !d_ill;
      jalr        <= d_jalr;
      illegal     <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
